// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder that drives one external
// 4-bit ripple slice nibble by nibble, least-significant first, and keeps
// the running carry in a register between passes.
// Optional feature macro: ADDER_OVERFLOW_EN adds a registered signed-overflow
// output (ovf) that updates together with Sum.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [3:0]       slice_A,
  output logic [3:0]       slice_B,
  output logic             slice_c_in,
  input  logic [3:0]       slice_S,
  input  logic             slice_c_out,
  output logic [WIDTH-1:0] Sum,
  output logic             c_out,
  output logic             busy,
  output logic             done
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned BW   = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] partial_q;
  logic [WIDTH-1:0] partial_d;
  logic [WIDTH-1:0] sum_q;
  logic [IDXW-1:0]  idx_q;
  logic [BW-1:0]    base_c;
  logic             carry_q;
  logic             c_out_q;
  logic             busy_q;
  logic             done_q;
`ifdef ADDER_OVERFLOW_EN
  logic             ovf_q;
`endif

  // Bit offset of the nibble currently being processed.
  assign base_c = BW'({idx_q, 2'b00});

  // Present the current operand nibbles and carry to the slice; quiet outside ADD.
  always_comb begin
    slice_A    = 4'h0;
    slice_B    = 4'h0;
    slice_c_in = 1'b0;
    if (state_q == S_ADD) begin
      slice_A    = opa_q[base_c +: 4];
      slice_B    = opb_q[base_c +: 4];
      slice_c_in = carry_q;
    end
  end

  // Partial sum with the slice result merged into the current nibble position.
  always_comb begin
    partial_d                = partial_q;
    partial_d[base_c +: 4]   = slice_S;
  end

  // Sequencer: latch operands on start, one slice pass per ADD cycle, pulse done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      partial_q <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      c_out_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ADDER_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (Run) begin
            opa_q     <= A;
            opb_q     <= B;
            carry_q   <= c_in;
            idx_q     <= '0;
            partial_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_ADD;
          end
        end
        S_ADD: begin
          partial_q <= partial_d;
          carry_q   <= slice_c_out;
          idx_q     <= idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            sum_q   <= partial_d;
            c_out_q <= slice_c_out;
`ifdef ADDER_OVERFLOW_EN
            ovf_q   <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                       (partial_d[WIDTH-1] != opa_q[WIDTH-1]);
`endif
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Sum   = sum_q;
  assign c_out = c_out_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef ADDER_OVERFLOW_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder with a behavioural 4-bit ripple slice and a
// scoreboard of expected {c_out, Sum} (and ovf when ADDER_OVERFLOW_EN is set).
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Run;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic [3:0]       slice_A;
  logic [3:0]       slice_B;
  logic             slice_c_in;
  logic [3:0]       slice_S;
  logic             slice_c_out;
  logic [WIDTH-1:0] Sum;
  logic             c_out;
  logic             busy;
  logic             done;
`ifdef ADDER_OVERFLOW_EN
  logic             ovf;
`endif

  typedef struct {
    logic [WIDTH:0] res;
    logic           ov;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Run         (Run),
    .A           (A),
    .B           (B),
    .c_in        (c_in),
    .slice_A     (slice_A),
    .slice_B     (slice_B),
    .slice_c_in  (slice_c_in),
    .slice_S     (slice_S),
    .slice_c_out (slice_c_out),
    .Sum         (Sum),
    .c_out       (c_out),
    .busy        (busy),
    .done        (done)
`ifdef ADDER_OVERFLOW_EN
    ,
    .ovf         (ovf)
`endif
  );

  // External combinational ripple slice.
  assign {slice_c_out, slice_S} = 5'(slice_A) + 5'(slice_B) + 5'(slice_c_in);

  always #5 Clk = ~Clk;

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic ci);
    exp_t e;
    e.res = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(ci);
    e.ov  = (a[WIDTH-1] == b[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Drive one add, push its expectation, observe 12 cycles after the start edge.
  task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input bit noise,
                        output logic [15:0] bmask, output int dcnt, output int dcyc,
                        output logic [WIDTH:0] res, output logic ov, output logic [3:0] s1);
    sb.push_back(model(a, b, ci));
    bmask = '0; dcnt = 0; dcyc = -1; res = 'x; ov = 1'bx; s1 = 'x;
    @(negedge Clk);
    A = a; B = b; c_in = ci; Run = 1'b1;
    @(posedge Clk);
    #1;
    Run = 1'b0; A = 16'($urandom); B = 16'($urandom); c_in = 1'($urandom);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge Clk);
      bmask[cyc] = busy;
      if (cyc == 1) s1 = slice_A;
      if (done) begin
        dcnt++;
        dcyc = cyc;
        res  = {c_out, Sum};
`ifdef ADDER_OVERFLOW_EN
        ov   = ovf;
`else
        ov   = 1'b0;
`endif
      end
      if (noise) begin
        Run = (cyc == 2 || cyc == 3);
        if (Run) begin
          A = 16'($urandom); B = 16'($urandom); c_in = 1'($urandom);
        end
      end
    end
    Run = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({c_out, Sum} !== 17'h0) $display("FAIL reset_sum: got %h expected 0", {c_out, Sum});
    else pass_cnt++;
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
    else pass_cnt++;
    total_cnt++;
    if ({slice_A, slice_B, slice_c_in} !== 9'h0)
      $display("FAIL reset_slice: got %h expected 0", {slice_A, slice_B, slice_c_in});
    else pass_cnt++;
`ifdef ADDER_OVERFLOW_EN
    total_cnt++;
    if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf);
    else pass_cnt++;
`endif
  endtask

  task automatic test_basic();
    logic [15:0] bm; int dc; int dy; logic [WIDTH:0] r; logic o; logic [3:0] s1; exp_t e;
    do_add(16'h1234, 16'h4321, 1'b0, 1'b0, bm, dc, dy, r, o, s1);
    e = sb.pop_front();
    total_cnt++;
    if (r !== e.res) $display("FAIL basic_sum: got %h expected %h", r, e.res);
    else pass_cnt++;
    total_cnt++;
    if (r !== 17'h05555) $display("FAIL basic_const: got %h expected 05555", r);
    else pass_cnt++;
    total_cnt++;
    if (dc !== 1 || dy !== 5) $display("FAIL basic_done: got cnt %0d cyc %0d expected 1/5", dc, dy);
    else pass_cnt++;
    total_cnt++;
    if (bm !== 16'h003E) $display("FAIL basic_busy: got %h expected 003e", bm);
    else pass_cnt++;
    total_cnt++;
    if (s1 !== 4'h4) $display("FAIL basic_slice_nib0: got %h expected 4", s1);
    else pass_cnt++;
  endtask

  task automatic test_carry_ripple();
    logic [15:0] bm; int dc; int dy; logic [WIDTH:0] r; logic o; logic [3:0] s1; exp_t e;
    do_add(16'hFFFF, 16'h0001, 1'b0, 1'b0, bm, dc, dy, r, o, s1);
    e = sb.pop_front();
    total_cnt++;
    if (r !== e.res || r !== 17'h10000) $display("FAIL ripple_sum: got %h expected %h", r, e.res);
    else pass_cnt++;
`ifdef ADDER_OVERFLOW_EN
    total_cnt++;
    if (o !== e.ov) $display("FAIL ripple_ovf: got %b expected %b", o, e.ov);
    else pass_cnt++;
`endif
  endtask

  task automatic test_overflow();
    logic [15:0] bm; int dc; int dy; logic [WIDTH:0] r; logic o; logic [3:0] s1; exp_t e;
    do_add(16'h7FFF, 16'h0001, 1'b0, 1'b0, bm, dc, dy, r, o, s1);
    e = sb.pop_front();
    total_cnt++;
    if (r !== e.res) $display("FAIL ovf1_sum: got %h expected %h", r, e.res);
    else pass_cnt++;
`ifdef ADDER_OVERFLOW_EN
    total_cnt++;
    if (o !== 1'b1) $display("FAIL ovf1_flag: got %b expected 1", o);
    else pass_cnt++;
`endif
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, bm, dc, dy, r, o, s1);
    e = sb.pop_front();
    total_cnt++;
    if (r !== e.res) $display("FAIL ovf2_sum: got %h expected %h", r, e.res);
    else pass_cnt++;
`ifdef ADDER_OVERFLOW_EN
    total_cnt++;
    if (o !== e.ov) $display("FAIL ovf2_flag: got %b expected %b", o, e.ov);
    else pass_cnt++;
`endif
  endtask

  task automatic test_run_ignored();
    logic [15:0] bm; int dc; int dy; logic [WIDTH:0] r; logic o; logic [3:0] s1; exp_t e;
    do_add(16'h0F0F, 16'h0101, 1'b0, 1'b1, bm, dc, dy, r, o, s1);
    e = sb.pop_front();
    total_cnt++;
    if (r !== e.res) $display("FAIL ignore_sum: got %h expected %h", r, e.res);
    else pass_cnt++;
    total_cnt++;
    if (dc !== 1) $display("FAIL ignore_done_cnt: got %0d expected 1", dc);
    else pass_cnt++;
    total_cnt++;
    if (bm !== 16'h003E) $display("FAIL ignore_busy: got %h expected 003e", bm);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_add();
    logic [15:0] bm; int dc; int dy; logic [WIDTH:0] r; logic o; logic [3:0] s1; exp_t e;
    int spurious;
    spurious = 0;
    @(negedge Clk);
    A = 16'hAAAA; B = 16'h5555; c_in = 1'b0; Run = 1'b1;
    @(posedge Clk);
    #1 Run = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({c_out, Sum} !== 17'h0) $display("FAIL midrst_sum: got %h expected 0", {c_out, Sum});
    else pass_cnt++;
    total_cnt++;
    if ({busy, done, slice_A} !== 6'h0) $display("FAIL midrst_ctrl: got %h expected 0", {busy, done, slice_A});
    else pass_cnt++;
    repeat (3) begin
      @(negedge Clk);
      if (done || busy) spurious++;
    end
    Reset_n = 1'b1;
    repeat (8) begin
      @(negedge Clk);
      if (done || busy) spurious++;
    end
    total_cnt++;
    if (spurious !== 0) $display("FAIL midrst_no_done: got %0d active cycles expected 0", spurious);
    else pass_cnt++;
    do_add(16'h0001, 16'h0001, 1'b0, 1'b0, bm, dc, dy, r, o, s1);
    e = sb.pop_front();
    total_cnt++;
    if (r !== e.res || r !== 17'h00002) $display("FAIL midrst_next_sum: got %h expected %h", r, e.res);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dq[$]; exp_t e;
    for (int k = 0; k < 3; k++) sb.push_back(model(16'h1357, 16'h8642, 1'b1));
    @(negedge Clk);
    A = 16'h1357; B = 16'h8642; c_in = 1'b1; Run = 1'b1;
    @(posedge Clk);
    #1;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge Clk);
      if (done) begin
        dq.push_back(cyc);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total_cnt++;
          if ({c_out, Sum} !== e.res) $display("FAIL b2b_sum: got %h expected %h", {c_out, Sum}, e.res);
          else pass_cnt++;
        end
      end
      if (cyc == 18) Run = 1'b0;
    end
    total_cnt++;
    if (dq.size() != 3) $display("FAIL b2b_done_count: got %0d expected 3", dq.size());
    else if (dq[0] != 5 || dq[1] != 11 || dq[2] != 17)
      $display("FAIL b2b_done_cycles: got %0d,%0d,%0d expected 5,11,17", dq[0], dq[1], dq[2]);
    else pass_cnt++;
    sb.delete();
  endtask

  initial begin
    Reset_n = 1'b0; Run = 1'b0; A = '0; B = '0; c_in = 1'b0;
    test_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
    test_basic();
    test_carry_ripple();
    test_overflow();
    test_run_ignored();
    test_reset_mid_add();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle 16-bit adder sequencer. It drives one external combinational 4-bit carry-ripple slice nibble by nibble, least-significant first, and holds the running carry in a register between cycles. It assembles the slice outputs into a full-width sum and signals completion with a one-cycle done pulse. It sits directly upstream of the 4-bit ripple slice, feeding its A/B/carry inputs, and also consumes the slice's S/carry outputs.

## Interface
- WIDTH, 16, operand width in bits; multiple of 4, minimum 4; NIB = WIDTH/4 slice passes.
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Run  input  1  start request; sampled only in IDLE.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- c_in  input  1  carry-in for the least-significant nibble.
- slice_A  output  4  nibble of latched A presented to the slice.
- slice_B  output  4  nibble of latched B presented to the slice.
- slice_c_in  output  1  carry into the slice (carry register).
- slice_S  input  4  slice sum, combinational from slice_A/B/c_in.
- slice_c_out  input  1  slice carry-out.
- Sum  output  WIDTH  result of last completed add; held until the next add completes.
- c_out  output  1  final carry of last completed add.
- busy  output  1  high in ADD and DONE.
- done  output  1  one-cycle pulse when Sum/c_out update.
- ovf  output  1  signed overflow of last add (only with ADDER_OVERFLOW_EN).

## Operation
- States: IDLE, ADD, DONE. Reset state: IDLE.
- IDLE, Run=1: latch A, B into opA/opB, load carry register with c_in, clear nibble index idx, clear partial-sum register, go to ADD.
- IDLE, Run=0: stay in IDLE.
- ADD: drive slice_A=opA[4*idx+:4], slice_B=opB[4*idx+:4], slice_c_in=carry.
  - Each edge: write slice_S into partial[4*idx+:4], load carry from slice_c_out, increment idx.
  - When idx=NIB-1, also copy the completed partial value and slice_c_out into Sum/c_out, then go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Run is ignored while busy. No queuing.
- A, B and c_in may change after the start edge without affecting the add in progress.
- Outside ADD, slice_A, slice_B and slice_c_in drive 0.
- idx counter width is max(1, clog2(NIB)). For NIB=1, ADD lasts one cycle.
- Arithmetic: {c_out, Sum} = opA + opB + c_in, modulo 2^(WIDTH+1).
- Reset (any time, including mid-ADD) forces IDLE and discards the partial result. Outputs reset to:
  - Sum = 0
  - c_out = 0
  - busy = 0
  - done = 0
  - ovf = 0
  - slice outputs = 0

## Timing
- Edge 0: Run sampled high in IDLE.
- Cycles 1..NIB: ADD.
- Edge NIB: Sum and c_out update.
- Cycle NIB+1: done=1. For WIDTH=16, done is high in cycle 5.
- Throughput: one add per NIB+2 cycles. Run held high continuously restarts in the IDLE cycle after DONE.
- busy rises the cycle after the start edge and falls the cycle after done.
- The slice path (opA/opB/carry → slice → partial/carry) is single-cycle combinational. There are no multicycle paths.
- Reset_n deasserts asynchronously. Run is not acted on until the first rising edge with Reset_n=1.

## Configuration
- ADDER_OVERFLOW_EN defined:
  - Port ovf exists.
  - ovf = (opA[WIDTH-1] == opB[WIDTH-1]) && (result[WIDTH-1] != opA[WIDTH-1]).
  - ovf updates together with Sum and holds with it.
- ADDER_OVERFLOW_EN undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- A=0x1234, B=0x4321, c_in=0, Run pulse → Sum=0x5555, c_out=0, done high exactly in cycle 5, busy high in cycles 1–5.
- A=0xFFFF, B=0x0001, c_in=0 → Sum=0x0000, c_out=1; ovf=0 (macro on). The carry ripples through all four nibble passes.
- A=0x7FFF, B=0x0001 → Sum=0x8000, c_out=0, ovf=1. A=0xFFFF, B=0xFFFF, c_in=1 → Sum=0xFFFF, c_out=1, ovf=0.
- Start 0x0F0F+0x0101, then assert Run with new operands in cycles 2–4 → result 0x1010 with a single done pulse; the second Run is ignored.
- Start 0xAAAA+0x5555, then pull Reset_n low in cycle 3 → immediate IDLE, Sum=0, c_out=0, busy=0, no done pulse. A following add of 0x0001+0x0001 yields 0x0002.
- Run held high for 20 cycles with fixed operands → done pulses at cycles 5, 11, 17, each with an identical Sum.
